uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a first-word-fall-through byte FIFO.
// Framing errors and FIFO overruns are reported as single-cycle pulses.
module uart_rx_fifo #(
   parameter int unsigned CLKS_PER_BIT = 208,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic                         i_Clock,
   input  logic                         i_Reset,
   input  logic                         i_RX_Serial,
   input  logic                         i_RD_En,
   output logic [7:0]                   o_RX_Byte,
   output logic                         o_Empty,
   output logic                         o_Full,
   output logic [$clog2(FIFO_DEPTH):0]  o_Count,
   output logic                         o_RX_Active,
   output logic                         o_Frame_Err,
   output logic                         o_Overrun
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] HALF_C  = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CW-1:0] LAST_C  = CW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } state_e;

   state_e          state_q;
   logic            rx_meta_q;
   logic            rx_s_q;
   logic [CW-1:0]   cnt_q;
   logic [2:0]      idx_q;
   logic [7:0]      shreg_q;
   logic            frame_err_q;
   logic            overrun_q;

   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q;
   logic [AW-1:0]   rd_ptr_q;
   logic [AW:0]     count_q;
   logic [AW:0]     count_d;

   logic            push_req;
   logic            push;
   logic            pop;
   logic            full;

   always_comb begin
      push_req = (state_q == ST_STOP) && (cnt_q == LAST_C) && rx_s_q;
      pop      = i_RD_En && (count_q != '0);
      full     = (count_q == DEPTH_C);
      // A same-cycle pop frees the slot, so a full FIFO still accepts the byte.
      push     = push_req && (!full || pop);
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!push && pop) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= i_RX_Serial;
         rx_s_q    <= rx_meta_q;
      end
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shreg_q     <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         overrun_q   <= push_req && full && !pop;
         case (state_q)
            ST_IDLE: begin
               if (!rx_s_q) begin
                  cnt_q   <= '0;
                  state_q <= ST_START;
               end
            end
            ST_START: begin
               if (cnt_q == HALF_C) begin
                  cnt_q   <= '0;
                  state_q <= rx_s_q ? ST_IDLE : ST_DATA;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_DATA: begin
               if (cnt_q == LAST_C) begin
                  cnt_q          <= '0;
                  shreg_q[idx_q] <= rx_s_q;
                  idx_q          <= idx_q + 1'b1;
                  if (idx_q == 3'd7) begin
                     state_q <= ST_STOP;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_STOP: begin
               if (cnt_q == LAST_C) begin
                  cnt_q <= '0;
                  if (rx_s_q) begin
                     state_q <= ST_IDLE;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= ST_BREAK;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_BREAK: begin
               if (rx_s_q) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_Clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= shreg_q;
      end
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_d;
      end
   end

   assign o_RX_Byte   = (count_q == '0) ? 8'h00 : mem_q[rd_ptr_q];
   assign o_Empty     = (count_q == '0);
   assign o_Full      = full;
   assign o_Count     = count_q;
   assign o_RX_Active = (state_q != ST_IDLE);
   assign o_Frame_Err = frame_err_q;
   assign o_Overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed frames plus random traffic, checked against a
// queue-based model with exact push/pulse timing derived from the frame rules.
module tb_uart_rx_fifo;

   localparam int CLKS      = 208;
   localparam int DEPTH     = 8;
   localparam int HALF      = (CLKS - 1) / 2;
   // Posedges after the start falling edge: 2 sync + detect + half bit + 9 bits.
   localparam int STOP_EDGE = 4 + HALF + 9 * CLKS;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       rd;
   logic [7:0] rx_byte;
   logic       empty;
   logic       full;
   logic [3:0] count;
   logic       active;
   logic       frame_err;
   logic       overrun;

   uart_rx_fifo #(
      .CLKS_PER_BIT (CLKS),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .i_Clock     (clk),
      .i_Reset     (rst),
      .i_RX_Serial (rx),
      .i_RD_En     (rd),
      .o_RX_Byte   (rx_byte),
      .o_Empty     (empty),
      .o_Full      (full),
      .o_Count     (count),
      .o_RX_Active (active),
      .o_Frame_Err (frame_err),
      .o_Overrun   (overrun)
   );

   always #5 clk = ~clk;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int fe_cyc    = 0;
   int ov_cyc    = 0;
   int both_cyc  = 0;
   int act_cyc   = 0;
   int over_cyc  = 0;

   logic [7:0] q [$];

   always @(negedge clk) begin
      if (frame_err) fe_cyc++;
      if (overrun) ov_cyc++;
      if (frame_err && overrun) both_cyc++;
      if (active) act_cyc++;
      if (count > DEPTH) over_cyc++;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
   endtask

   function automatic logic [7:0] head_exp();
      return (q.size() > 0) ? q[0] : 8'h00;
   endfunction

   task automatic check_fifo(input string tag);
      check({tag, ".count"}, 32'(count), 32'(q.size()));
      check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
      check({tag, ".full"},  32'(full),  32'(q.size() == DEPTH));
      check({tag, ".head"},  32'(rx_byte), 32'(head_exp()));
   endtask

   task automatic check_reset_vals(input string tag);
      check_fifo(tag);
      check({tag, ".active"}, 32'(active), 32'd0);
      check({tag, ".ferr"},   32'(frame_err), 32'd0);
      check({tag, ".ovr"},    32'(overrun), 32'd0);
   endtask

   task automatic pop_check(input string tag);
      @(negedge clk);
      check({tag, ".pre_head"}, 32'(rx_byte), 32'(head_exp()));
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      if (q.size() > 0) void'(q.pop_front());
      check_fifo(tag);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_b, input bit pop_at_stop);
      logic [9:0] bits;
      logic       exp_ov;
      string      tag;
      bits = {stop_b, b, 1'b0};
      tag  = $sformatf("frame_%02h", b);
      for (int c = 0; c < 10 * CLKS; c++) begin
         @(negedge clk);
         if (c == STOP_EDGE - 1) begin
            check({tag, ".pre_count"}, 32'(count), 32'(q.size()));
         end
         if (c == STOP_EDGE) begin
            exp_ov = 1'b0;
            if (pop_at_stop && q.size() > 0) void'(q.pop_front());
            if (stop_b) begin
               if (q.size() < DEPTH) q.push_back(b);
               else exp_ov = 1'b1;
            end
            check({tag, ".ferr"}, 32'(frame_err), 32'(!stop_b));
            check({tag, ".ovr"},  32'(overrun), 32'(exp_ov));
            check_fifo(tag);
         end
         rx = bits[c / CLKS];
         if (pop_at_stop) rd = (c == STOP_EDGE - 1);
      end
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int fe0, ov0, act0, d;
      logic [7:0] b;
      logic [9:0] bits;

      rst = 1'b1;
      rx  = 1'b1;
      rd  = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst = 1'b0;
      idle(5);
      pop_check("pop_empty");

      // Single good byte, then read it out.
      fe0 = fe_cyc; ov0 = ov_cyc;
      send_frame(8'h3F, 1'b1, 1'b0);
      idle(CLKS);
      pop_check("pop_3f");
      check("byte3f.no_pulses", 32'((fe_cyc - fe0) + (ov_cyc - ov0)), 32'd0);

      // Bad stop bit followed by a long break, then a good byte.
      fe0 = fe_cyc; ov0 = ov_cyc;
      send_frame(8'h55, 1'b0, 1'b0);
      rx = 1'b0;
      repeat (20 * CLKS) @(negedge clk);
      idle(2 * CLKS);
      send_frame(8'hA5, 1'b1, 1'b0);
      idle(CLKS);
      check("break.ferr_cycles", 32'(fe_cyc - fe0), 32'd1);
      check("break.ovr_cycles",  32'(ov_cyc - ov0), 32'd0);
      check_fifo("break.after_a5");
      pop_check("pop_a5");

      // Short low glitch must be rejected at the start-bit midpoint.
      fe0 = fe_cyc; ov0 = ov_cyc; act0 = act_cyc;
      @(negedge clk);
      rx = 1'b0;
      repeat (50) @(negedge clk);
      idle(300);
      d = act_cyc - act0;
      check("glitch.active_bounded", 32'(d >= 1 && d <= 106), 32'd1);
      check("glitch.active_now", 32'(active), 32'd0);
      check("glitch.pulses", 32'((fe_cyc - fe0) + (ov_cyc - ov0)), 32'd0);
      check_fifo("glitch");

      // Fill, overrun, then push-with-pop while full.
      for (int i = 0; i < DEPTH; i++) begin
         send_frame(8'(i), 1'b1, 1'b0);
         idle(CLKS);
      end
      check("fill.full", 32'(full), 32'd1);
      ov0 = ov_cyc;
      send_frame(8'hAA, 1'b1, 1'b0);
      idle(CLKS);
      check("overrun.cycles", 32'(ov_cyc - ov0), 32'd1);
      check_fifo("overrun.intact");
      ov0 = ov_cyc;
      send_frame(8'h5A, 1'b1, 1'b1);
      idle(CLKS);
      check("fullpop.no_ovr", 32'(ov_cyc - ov0), 32'd0);
      for (int i = 0; i < DEPTH; i++) pop_check($sformatf("drain%0d", i));

      // Random traffic with interleaved reads.
      for (int n = 0; n < 6; n++) begin
         b = 8'($urandom);
         send_frame(b, 1'b1, bit'($urandom_range(0, 1)));
         idle(CLKS + int'($urandom_range(0, 40)));
         for (int k = 0; k < int'($urandom_range(0, 2)); k++) pop_check($sformatf("rnd%0d_%0d", n, k));
      end
      send_frame(8'h11, 1'b1, 1'b0);
      idle(CLKS);

      // Reset during data bit 4 of 0x96, then a clean 0xC3.
      fe0 = fe_cyc; ov0 = ov_cyc;
      bits = {1'b1, 8'h96, 1'b0};
      for (int c = 0; c <= 5 * CLKS + CLKS / 2; c++) begin
         @(negedge clk);
         rx = bits[c / CLKS];
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      check_reset_vals("midreset");
      idle(12 * CLKS);
      check("midreset.pulses", 32'((fe_cyc - fe0) + (ov_cyc - ov0)), 32'd0);
      check_fifo("midreset.idle");
      send_frame(8'hC3, 1'b1, 1'b0);
      idle(CLKS);
      check_fifo("after_c3");

      check("never_both_pulses", 32'(both_cyc), 32'd0);
      check("count_never_over", 32'(over_cyc), 32'd0);
      check("total_ferr_cycles", 32'(fe_cyc), 32'd1);
      check("total_ovr_cycles",  32'(ov_cyc), 32'd1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
